// File: rtl/sd_read_arbiter_pkg.sv
// Shared types and default sizing for the SD sector-read arbiter.
package sd_arb_pkg;

    localparam int DEF_NUM_REQ     = 2;
    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_TIMEOUT_CYC = 1048576;

    // One sector read per grant: pick, issue, wait for the engine, stream, finish.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        XFER      = 3'd3,
        DONE      = 3'd4
    } arb_state_e;

endpackage

// File: rtl/sd_read_arbiter_if.sv
// Sector-read port between the arbiter (master) and the SD command/data engine (slave).
interface sd_read_arbiter_if
    import sd_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              rd_start_en;
    logic [ADDR_W-1:0] rd_sec_addr;
    logic              rd_busy;
    logic              rd_val_en;
    logic [DATA_W-1:0] rd_val_data;

    modport master (
        output rd_start_en,
        output rd_sec_addr,
        input  rd_busy,
        input  rd_val_en,
        input  rd_val_data
    );

    modport slave (
        input  rd_start_en,
        input  rd_sec_addr,
        output rd_busy,
        output rd_val_en,
        output rd_val_data
    );

endinterface

// File: rtl/sd_read_arbiter_rr_pick.sv
// Round-robin priority selector: first set request bit after ptr, wrapping.
// Purely combinational; the pointer itself lives in the arbiter top.
module sd_rr_pick
    import sd_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       valid,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    // Scan from the farthest candidate to the nearest so the nearest set bit
    // after ptr is the last one written and therefore wins.
    always_comb begin
        // NOTE: every output gets a default before the loop; without it the
        // no-request path would leave idx unassigned and infer a latch.
        valid = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int cand;
            cand = (int'(ptr) + k) % NUM_REQ;
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand[$clog2(NUM_REQ)-1:0];
            end
        end
    end

endmodule

// File: rtl/sd_read_arbiter.sv
// SD sector-read arbiter: shares one SD read port between NUM_REQ requesters,
// round-robin, one sector per grant, read data routed only to the owner.
// Optional watchdog: define SD_ARB_TIMEOUT_EN to abort a transfer after
// TIMEOUT_CYC cycles in WAIT_BUSY/XFER and raise a sticky timeout_err.
module sd_read_arbiter
    import sd_arb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                        sd_clk,
    input  logic                        rst_n,
    input  logic                        sd_init_done,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_sec_addr,
    output logic [NUM_REQ-1:0]          ack,
    output logic [NUM_REQ-1:0]          done,
    output logic [NUM_REQ-1:0]          val_en,
    output logic [DATA_W-1:0]           val_data,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        arb_busy,
    output logic                        timeout_err,
    sd_read_arbiter_if.master           sd
);

    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("sd_read_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic [ADDR_W-1:0] sec_addr_q;
    logic              start_c;
    logic              route;
    logic              timed_out;

    sd_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Data beats are only meaningful while the granted read is in flight.
    assign route    = (state_q == WAIT_BUSY) || (state_q == XFER);
    assign arb_busy = (state_q != IDLE);

    assign sd.rd_start_en = start_c;
    assign sd.rd_sec_addr = sec_addr_q;

`ifdef SD_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wd_cnt_q;
    logic             wd_err_q;

    assign timed_out   = route && (wd_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign timeout_err = wd_err_q;

    // Watchdog: cleared in ISSUE so it starts at 0 on entering WAIT_BUSY.
    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            wd_cnt_q <= '0;
        end else if (route) begin
            wd_cnt_q <= wd_cnt_q + CNT_W'(1);
        end
    end

    // Sticky error: only a reset clears it.
    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_err_q <= 1'b0;
        end else if (timed_out) begin
            wd_err_q <= 1'b1;
        end
    end
`else
    assign timed_out   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge sd_clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode plus the single-cycle ISSUE/DONE pulses.
    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        ack     = '0;
        done    = '0;
        unique case (state_q)
            IDLE: begin
                if (sd_init_done && pick_valid) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                start_c       = 1'b1;
                ack[grant_id] = 1'b1;
                state_d       = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (timed_out) begin
                    state_d = DONE;
                end else if (sd.rd_busy) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                if (timed_out || !sd.rd_busy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done[grant_id] = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Grant bookkeeping: owner and address latched at the decision, pointer
    // advanced once the command is issued.
    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id   <= '0;
            sec_addr_q <= '0;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
        end else begin
            if (state_q == IDLE && state_d == ISSUE) begin
                grant_id   <= pick_idx;
                sec_addr_q <= req_sec_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            end
            if (state_q == ISSUE) begin
                ptr_q <= grant_id;
            end
        end
    end

    // Registered data routing: one cycle latency, only the owner sees val_en.
    always_ff @(posedge sd_clk or negedge rst_n) begin
        if (!rst_n) begin
            val_en   <= '0;
            val_data <= '0;
        end else begin
            val_en <= (route && sd.rd_val_en) ? (NUM_REQ'(1) << grant_id) : '0;
            if (route) begin
                val_data <= sd.rd_val_data;
            end
        end
    end

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Randomized self-checking bench for sd_read_arbiter against a cycle-level
// transaction model (round-robin choice, engine busy window, routed beats).
module tb_sd_read_arbiter;
    import sd_arb_pkg::*;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 16;
    localparam int TO = 64;
    localparam int IW = $clog2(NR);

    logic             sd_clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sd_init_done = 1'b0;
    logic [NR-1:0]    req = '0;
    logic [NR*AW-1:0] req_sec_addr = '0;
    logic [NR-1:0]    ack, done, val_en;
    logic [DW-1:0]    val_data;
    logic [IW-1:0]    grant_id;
    logic             arb_busy, timeout_err;

    sd_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) sd_bus ();

    sd_read_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .sd_clk       (sd_clk),
        .rst_n        (rst_n),
        .sd_init_done (sd_init_done),
        .req          (req),
        .req_sec_addr (req_sec_addr),
        .ack          (ack),
        .done         (done),
        .val_en       (val_en),
        .val_data     (val_data),
        .grant_id     (grant_id),
        .arb_busy     (arb_busy),
        .timeout_err  (timeout_err),
        .sd           (sd_bus)
    );

    always #5 sd_clk = ~sd_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model state.
    int            last_winner, owner;
    logic [AW-1:0] owner_addr;
    bit            txn_active, idle_prev, done_prev, busy_drop_prev, route_prev;
    logic [DW-1:0] exp_vdata;
    // Stimulus controls.
    bit check_en = 1, rand_req = 0, rand_init = 0, stray_en = 0, hold_req = 0, no_busy = 0;
    int fix_len = 0, fix_beats = 0;
    // Behavioural SD engine.
    int eng_phase, eng_delay, eng_len, eng_idx;
    // Statistics.
    int start_cnt = 0;
    int beat_cnt[NR];
    int done_cnt[NR];
    int grant_q[$];

    function automatic int rr_pick(logic [NR-1:0] r, int last);
        for (int k = 1; k <= NR; k++) begin
            int j;
            j = (last + k) % NR;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        last_winner    = NR - 1;
        owner          = 0;
        owner_addr     = '0;
        txn_active     = 0;
        idle_prev      = 1;
        done_prev      = 0;
        busy_drop_prev = 0;
        route_prev     = 0;
        exp_vdata      = '0;
        eng_phase      = 0;
        eng_delay      = 0;
        eng_len        = 0;
        eng_idx        = 0;
    endtask

    task automatic do_reset();
        rst_n              = 1'b0;
        req                = '0;
        sd_bus.rd_busy     = 1'b0;
        sd_bus.rd_val_en   = 1'b0;
        sd_bus.rd_val_data = '0;
        model_reset();
        repeat (2) @(negedge sd_clk);
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(string pfx);
        check({pfx, "_ack"}, ack, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_val_en"}, val_en, 0);
        check({pfx, "_val_data"}, val_data, 0);
        check({pfx, "_grant_id"}, grant_id, 0);
        check({pfx, "_arb_busy"}, arb_busy, 0);
        check({pfx, "_timeout_err"}, timeout_err, 0);
        check({pfx, "_rd_start_en"}, sd_bus.rd_start_en, 0);
        check({pfx, "_rd_sec_addr"}, sd_bus.rd_sec_addr, 0);
    endtask

    // One clock: compare DUT against the model, then drive the next inputs.
    task automatic step();
        int            w;
        bit            exp_start, exp_done, idle_now, route_now, drop_now;
        logic [NR-1:0] exp_ve;
        @(negedge sd_clk);
        w         = rr_pick(req, last_winner);
        exp_start = idle_prev && sd_init_done && (req != '0);
        exp_done  = busy_drop_prev;
        idle_now  = !exp_start && (idle_prev || done_prev);
        route_now = txn_active && !exp_done;
        exp_ve    = (route_prev && sd_bus.rd_val_en) ? (NR'(1) << owner) : '0;
        if (route_prev) exp_vdata = sd_bus.rd_val_data;
        if (check_en) begin
            check("rd_start_en", sd_bus.rd_start_en, exp_start);
            if (exp_start) begin
                check("ack", ack, NR'(1) << w);
                check("grant_id", grant_id, w);
                check("rd_sec_addr", sd_bus.rd_sec_addr, req_sec_addr[w*AW +: AW]);
            end else begin
                check("ack_quiet", ack, 0);
            end
            check("done", done, exp_done ? (NR'(1) << owner) : '0);
            if (exp_done) begin
                check("grant_hold", grant_id, owner);
                check("addr_hold", sd_bus.rd_sec_addr, owner_addr);
            end
            check("val_en", val_en, exp_ve);
            check("val_data", val_data, exp_vdata);
            check("arb_busy", arb_busy, !idle_now);
            check("timeout_err", timeout_err, 0);
        end
        if (sd_bus.rd_start_en) start_cnt++;
        for (int i = 0; i < NR; i++) begin
            beat_cnt[i] += int'(val_en[i]);
            done_cnt[i] += int'(done[i]);
            if (ack[i]) grant_q.push_back(i);
        end
        // Model transaction bookkeeping.
        if (exp_done) txn_active = 0;
        if (exp_start) begin
            owner       = w;
            last_winner = w;
            owner_addr  = req_sec_addr[w*AW +: AW];
            txn_active  = 1;
            if (!hold_req) req[w] = 1'b0;
            eng_phase = 1;
            eng_delay = $urandom_range(4, 2);
        end
        // SD engine response.
        drop_now           = 0;
        sd_bus.rd_val_en   = 1'b0;
        sd_bus.rd_val_data = DW'($urandom);
        case (eng_phase)
            1: begin
                eng_delay--;
                if (eng_delay == 0 && !no_busy) begin
                    sd_bus.rd_busy = 1'b1;
                    eng_len        = (fix_len > 0) ? fix_len : $urandom_range(20, 1);
                    eng_idx        = 0;
                    eng_phase      = 2;
                end
            end
            2: begin
                if (eng_len == 0) begin
                    sd_bus.rd_busy = 1'b0;
                    drop_now       = 1;
                    eng_phase      = 0;
                end else begin
                    sd_bus.rd_val_en = (fix_len > 0) ? (eng_idx < fix_beats)
                                                     : 1'($urandom_range(1, 0));
                    eng_idx++;
                    eng_len--;
                end
            end
            default: begin
                if (stray_en && !txn_active) sd_bus.rd_val_en = 1'($urandom_range(1, 0));
            end
        endcase
        // Random requesters: raise with a fresh address, occasionally withdraw.
        if (rand_req) begin
            for (int i = 0; i < NR; i++) begin
                if (!req[i] && $urandom_range(3, 0) == 0) begin
                    req[i]                 = 1'b1;
                    req_sec_addr[i*AW +: AW] = AW'($urandom);
                end else if (req[i] && $urandom_range(31, 0) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
        if (rand_init && $urandom_range(39, 0) == 0) sd_init_done = !sd_init_done;
        idle_prev      = idle_now;
        done_prev      = exp_done;
        busy_drop_prev = drop_now;
        route_prev     = route_now;
    endtask

    task automatic wait_idle(int max_cyc);
        bit ok;
        ok = 0;
        for (int c = 0; c < max_cyc; c++) begin
            step();
            if (!txn_active && idle_prev && req == '0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("idle_wait_expired", 0, 1);
    endtask

    initial begin
        int s0, b0, b1, d0, d1, n;
        bit seen;
        sd_bus.rd_busy     = 1'b0;
        sd_bus.rd_val_en   = 1'b0;
        sd_bus.rd_val_data = '0;
        for (int i = 0; i < NR; i++) begin
            beat_cnt[i] = 0;
            done_cnt[i] = 0;
        end
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge sd_clk);
        rst_n        = 1'b1;
        sd_init_done = 1'b1;

        // Single request: long busy window with 256 beats.
        req_sec_addr[0 +: AW] = 32'h0000_1000;
        req       = 2'b01;
        fix_len   = 600;
        fix_beats = 256;
        s0 = start_cnt; b0 = beat_cnt[0]; b1 = beat_cnt[1]; d0 = done_cnt[0];
        wait_idle(800);
        check("single_starts", start_cnt - s0, 1);
        check("single_beats0", beat_cnt[0] - b0, 256);
        check("single_beats1", beat_cnt[1] - b1, 0);
        check("single_done0", done_cnt[0] - d0, 1);
        fix_len = 0;

        // Contention from reset: requests held, expect 0,1,0,1.
        do_reset();
        hold_req = 1;
        req_sec_addr[0 +: AW]  = 32'h100;
        req_sec_addr[AW +: AW] = 32'h200;
        req = 2'b11;
        grant_q.delete();
        d0 = done_cnt[0] + done_cnt[1];
        seen = 0;
        for (int c = 0; c < 400; c++) begin
            step();
            if (done_cnt[0] + done_cnt[1] - d0 >= 4) begin
                seen = 1;
                break;
            end
        end
        check("contend_completed", seen, 1);
        req      = '0;
        hold_req = 0;
        wait_idle(100);
        check("contend_grants", grant_q.size(), 4);
        for (int i = 0; i < 4 && i < grant_q.size(); i++) check("contend_order", grant_q[i], i % 2);

        // Init gate.
        sd_init_done = 1'b0;
        req_sec_addr[0 +: AW] = 32'h55;
        req = 2'b01;
        s0  = start_cnt;
        repeat (50) step();
        check("init_gate_blocked", start_cnt - s0, 0);
        sd_init_done = 1'b1;
        repeat (2) step();
        check("init_gate_release", start_cnt - s0, 1);
        wait_idle(100);

        // Stray data in IDLE must not reach any requester.
        stray_en = 1;
        b0 = beat_cnt[0]; b1 = beat_cnt[1];
        repeat (40) step();
        check("stray_val_en0", beat_cnt[0] - b0, 0);
        check("stray_val_en1", beat_cnt[1] - b1, 0);

        // Randomized traffic with init toggling and stray beats.
        rand_req  = 1;
        rand_init = 1;
        s0 = start_cnt; d0 = done_cnt[0] + done_cnt[1];
        repeat (3000) step();
        rand_req     = 0;
        rand_init    = 0;
        stray_en     = 0;
        sd_init_done = 1'b1;
        req          = '0;
        wait_idle(200);
        check("random_balance", done_cnt[0] + done_cnt[1] - d0, start_cnt - s0);

        // Asynchronous reset in the middle of a transfer.
        req_sec_addr[0 +: AW] = 32'hABCD;
        req     = 2'b01;
        fix_len = 100;
        seen    = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (eng_phase == 2) begin
                seen = 1;
                break;
            end
        end
        check("xfer_reached", seen, 1);
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        do_reset();
        fix_len = 0;
        req_sec_addr[AW +: AW] = 32'h777;
        req = 2'b10;
        s0 = start_cnt; d1 = done_cnt[1];
        wait_idle(100);
        check("post_rst_start", start_cnt - s0, 1);
        check("post_rst_done1", done_cnt[1] - d1, 1);

        // Hung engine: busy never rises.
        do_reset();
        check_en = 0;
        no_busy  = 1;
        req      = 2'b01;
        s0       = start_cnt;
        for (int c = 0; c < 10 && start_cnt == s0; c++) step();
        check("hang_started", start_cnt - s0, 1);
        d0 = done_cnt[0];
        n  = 0;
        for (int c = 0; c < 200 && done_cnt[0] == d0; c++) begin
            step();
            n++;
        end
`ifdef SD_ARB_TIMEOUT_EN
        check("timeout_latency_ok", (n >= 64 && n <= 67), 1);
        check("timeout_err_set", timeout_err, 1);
        repeat (20) step();
        check("timeout_err_sticky", timeout_err, 1);
        check("timeout_recovered", arb_busy, 0);
`else
        check("hang_no_done", done_cnt[0] - d0, 0);
        check("hang_arb_busy", arb_busy, 1);
        check("hang_no_err", timeout_err, 0);
`endif
        no_busy  = 0;
        do_reset();
        check_en = 1;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sd_read_arbiter.md
Name: sd_read_arbiter

Overview:
- Shares the single SD-card sector-read port (rd_start_en / rd_sec_addr / rd_busy / rd_val_en / rd_val_data) between NUM_REQ requesters, e.g. the audio streaming reader and a FAT/directory lookup reader.
- Grants round-robin, issues one sector read per grant, and routes the returned data beats only to the owner.
- Signals command issue and sector completion per requester.
- Sits between the SD command/data engine and the per-stream read controllers, in the sd_clk domain.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 32, sector address width
DATA_W, 16, read data width
TIMEOUT_CYC, 1048576, watchdog limit in sd_clk cycles (used only with SD_ARB_TIMEOUT_EN)

Ports:
sd_clk  in  1  SD working clock; all logic on rising edge
rst_n  in  1  asynchronous reset, active low
sd_init_done  in  1  SD card initialised; no grant while low
req  in  NUM_REQ  per-requester read request, level, held until ack
req_sec_addr  in  NUM_REQ*ADDR_W  packed sector addresses; requester i at [i*ADDR_W +: ADDR_W]
ack  out  NUM_REQ  1-cycle pulse: command issued for requester i
done  out  NUM_REQ  1-cycle pulse: sector for requester i finished
val_en  out  NUM_REQ  routed, registered rd_val_en
val_data  out  DATA_W  registered rd_val_data (broadcast)
grant_id  out  $clog2(NUM_REQ)  current/last owner index
arb_busy  out  1  high in any state except IDLE
timeout_err  out  1  sticky watchdog error
rd_start_en  out  1  start-read pulse to SD engine
rd_sec_addr  out  ADDR_W  sector address to SD engine
rd_busy  in  1  SD engine read busy
rd_val_en  in  1  SD read data valid
rd_val_data  in  DATA_W  SD read data

Behaviour:
- Reset values: all outputs 0. Round-robin pointer = NUM_REQ-1, so requester 0 wins first.
- Asynchronous reset mid-transfer aborts immediately. The SD engine is not notified.
- FSM states: IDLE, ISSUE, WAIT_BUSY, XFER, DONE.
- IDLE:
  - If sd_init_done=1 and req≠0, pick the first set bit searching from pointer+1 with wrap.
  - Latch grant_id and rd_sec_addr from req_sec_addr[grant_id], then go to ISSUE.
  - Only one grant per decision cycle.
- ISSUE (exactly 1 cycle): rd_start_en=1, ack[grant_id]=1, pointer←grant_id, then go to WAIT_BUSY.
- WAIT_BUSY: stay until rd_busy=1, then go to XFER.
- XFER: stay until rd_busy=0, then go to DONE.
- DONE (exactly 1 cycle): done[grant_id]=1, then go to IDLE. A new grant is possible on the next cycle, so minimum spacing between rd_start_en pulses is 4 cycles + the SD busy time.
- Data routing:
  - In WAIT_BUSY and XFER: val_en[grant_id] ← rd_val_en; val_data ← rd_val_data.
  - Fixed 1-cycle latency; other val_en bits stay 0.
- rd_val_en in IDLE, ISSUE or DONE is discarded: val_en=0, val_data holds its previous value.
- rd_sec_addr and grant_id are stable from ISSUE through DONE and hold afterwards.
- req deasserted after ack is ignored; the transfer completes.
- req deasserted before grant means no transaction.
- sd_init_done falling mid-transaction: the current sector completes; no new grant until it returns high.
- Fairness: a requester holding req continuously is served at most once per NUM_REQ grants while others are requesting.

Optional Feature:
SD_ARB_TIMEOUT_EN
- Defined:
  - A cycle counter clears on entering WAIT_BUSY and runs through WAIT_BUSY and XFER.
  - When it reaches TIMEOUT_CYC, go to DONE (done pulse still issued) and set timeout_err. timeout_err is sticky until rst_n.
  - This prevents a hung SD engine from locking out every requester.
- Undefined: no counter; WAIT_BUSY/XFER wait indefinitely; timeout_err tied 0 (port always present).

Decomposition:
- Package sd_arb_pkg holds:
  - state enum (IDLE, ISSUE, WAIT_BUSY, XFER, DONE)
  - default NUM_REQ/ADDR_W/DATA_W constants
  - TIMEOUT_CYC default
- One sub-module: sd_rr_pick, a round-robin priority selector (req vector + pointer → valid + index). It is combinational; all state stays in the top.

Test Plan:
- Single request: req=01, addr0=0x0000_1000; engine busy 600 cycles with 256 val beats → exactly one rd_start_en with rd_sec_addr=0x1000, ack[0] 1 cycle, 256 val_en[0] pulses delayed 1 cycle, val_en[1]=0, done[0] once.
- Contention: req=11 held, addr0=0x100, addr1=0x200, 4 sectors → grant order 0,1,0,1; addresses match; no overlapping rd_start_en.
- Init gate: req=01 with sd_init_done=0 for 50 cycles → no rd_start_en; sd_init_done→1 → rd_start_en within 2 cycles.
- Stray data: rd_val_en pulsed in IDLE → all val_en stay 0. Reset asserted mid-XFER → all outputs 0 asynchronously; FSM back in IDLE after release.
- Timeout (macro on, TIMEOUT_CYC=64): rd_busy never rises → done[0] at ~cycle 66 after ISSUE, timeout_err=1 and stays 1. Macro off, same stimulus → arb_busy stays 1, timeout_err=0.
